// File: rtl/demux_stream_pkg.sv
// ============================================================================
// Module : demux_stream_pkg
// Brief  : Shared defaults and channel-slice helper for the stream demux/mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_stream_pkg;

  localparam int BUS_SIZE_DEF   = 32;
  localparam int DROP_WIDTH_DEF = 8;

  // LSB of channel k inside a flattened CHANNELS*width bus
  function automatic int chan_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_stream_if.sv
// ============================================================================
// Module : demux_stream_if
// Brief  : Input stream plus per-channel output handshake of the demux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface demux_stream_if
  import demux_stream_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int BUS_SIZE  = BUS_SIZE_DEF,
  parameter int SEL_WIDTH = $clog2(CHANNELS)
);

  logic                         in_valid;
  logic                         in_ready;
  logic [SEL_WIDTH-1:0]         in_selector;
  logic [BUS_SIZE-1:0]          in_data;
  logic [CHANNELS-1:0]          out_valid;
  logic [CHANNELS-1:0]          out_ready;
  logic [CHANNELS*BUS_SIZE-1:0] out_data;

  modport master (
    output in_valid, in_selector, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_selector, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

`default_nettype wire

// File: rtl/demux_stream_slot.sv
// ============================================================================
// Module : demux_slot
// Brief  : One-entry holding register with fill/drain for a demux channel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_slot #(
  parameter int BUS_SIZE = 32
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                fill,
  input  wire logic                drain,
  input  wire logic [BUS_SIZE-1:0] fill_data,
  output logic                     valid,
  output logic [BUS_SIZE-1:0]      data
);

  logic                r_valid;
  logic [BUS_SIZE-1:0] r_data;

  // A fill on the same edge as a drain wins, so the slot never bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (fill) begin
      r_valid <= 1'b1;
      r_data  <= fill_data;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule

`default_nettype wire

// File: rtl/demux_stream.sv
// ============================================================================
// Module : demux_stream
// Brief  : Registered 1-to-N stream demultiplexer with per-channel slots.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int BUS_SIZE   = BUS_SIZE_DEF,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF
) (
  input  wire logic              clk,
  input  wire logic              reset,
  demux_stream_if.slave          bus,
  output logic                   busy,
  output logic [DROP_WIDTH-1:0]  drop_count
);

  localparam int                 SEL_WIDTH  = $clog2(CHANNELS);
  localparam logic [SEL_WIDTH:0] c_channels = CHANNELS[SEL_WIDTH:0];

  logic                  w_in_range;
  logic                  w_target_free;
  logic                  w_accept;
  logic [CHANNELS-1:0]   w_sel_hot;
  logic [CHANNELS-1:0]   w_slot_free;
  logic [CHANNELS-1:0]   w_fill;
  logic [CHANNELS-1:0]   w_drain;
  logic [CHANNELS-1:0]   w_valid;
  logic [DROP_WIDTH-1:0] r_drop_count;

  always_comb begin
    w_sel_hot = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_sel_hot[k] = (bus.in_selector == SEL_WIDTH'(k));
    end
  end

  // Constant-true when CHANNELS is a power of two
  assign w_in_range    = ({1'b0, bus.in_selector} < c_channels);
  assign w_slot_free   = ~w_valid | bus.out_ready;
  assign w_target_free = |(w_sel_hot & w_slot_free);
  assign bus.in_ready  = !reset && (w_in_range ? w_target_free : 1'b1);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_fill        = {CHANNELS{w_accept}} & w_sel_hot;
  assign w_drain       = w_valid & bus.out_ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    demux_slot #(
      .BUS_SIZE (BUS_SIZE)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .fill      (w_fill[k]),
      .drain     (w_drain[k]),
      .fill_data (bus.in_data),
      .valid     (w_valid[k]),
      .data      (bus.out_data[chan_lsb(k, BUS_SIZE) +: BUS_SIZE])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_accept && !w_in_range && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + DROP_WIDTH'(1);
    end
  end

  assign bus.out_valid = w_valid;
  assign busy          = |w_valid;
  assign drop_count    = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_demux_stream.sv
// ============================================================================
// Module : tb_demux_stream
// Brief  : Bench for demux_stream, 4-channel and 3-channel instances side by side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_stream;

  localparam int BW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  demux_stream_if #(.CHANNELS(4), .BUS_SIZE(BW)) bus4 ();
  demux_stream_if #(.CHANNELS(3), .BUS_SIZE(BW)) bus3 ();

  logic       busy4, busy3;
  logic [7:0] drop4, drop3;

  demux_stream #(.CHANNELS(4), .BUS_SIZE(BW), .DROP_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave), .busy(busy4), .drop_count(drop4));
  demux_stream #(.CHANNELS(3), .BUS_SIZE(BW), .DROP_WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave), .busy(busy3), .drop_count(drop3));

  // Stimulus, index 0 -> 4-channel DUT, index 1 -> 3-channel DUT
  logic        iv   [2];
  logic [1:0]  sel  [2];
  logic [31:0] din  [2];
  logic [3:0]  ordy [2];

  assign bus4.in_valid    = iv[0];
  assign bus4.in_selector = sel[0];
  assign bus4.in_data     = din[0];
  assign bus4.out_ready   = ordy[0];
  assign bus3.in_valid    = iv[1];
  assign bus3.in_selector = sel[1];
  assign bus3.in_data     = din[1];
  assign bus3.out_ready   = ordy[1][2:0];

  logic        ir  [2];
  logic [3:0]  ov  [2];
  logic        bsy [2];
  logic [7:0]  drp [2];
  logic [31:0] od  [2][4];

  always_comb begin
    ir[0]  = bus4.in_ready;
    ir[1]  = bus3.in_ready;
    ov[0]  = bus4.out_valid;
    ov[1]  = {1'b0, bus3.out_valid};
    bsy[0] = busy4;
    bsy[1] = busy3;
    drp[0] = drop4;
    drp[1] = drop3;
    for (int k = 0; k < 4; k++) begin
      od[0][k] = bus4.out_data[BW*k +: BW];
      od[1][k] = '0;
    end
    for (int k = 0; k < 3; k++) od[1][k] = bus3.out_data[BW*k +: BW];
  end

  // Reference model: per-channel queue of words not yet consumed,
  // last word written to each channel, and dropped-word count.
  logic [31:0] q    [2][4][$];
  logic [31:0] last [2][4];
  int          drops[2];
  int          nch  [2] = '{4, 3};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic exp_ready(input int d);
    int s;
    s = int'(sel[d]);
    if (reset) return 1'b0;
    if (s >= nch[d]) return 1'b1;
    return (q[d][s].size() == 0) || ordy[d][s];
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      drops[d] = 0;
      for (int k = 0; k < 4; k++) begin
        q[d][k].delete();
        last[d][k] = '0;
      end
    end
  endtask

  task automatic verify();
    logic any;
    for (int d = 0; d < 2; d++) begin
      any = 1'b0;
      check($sformatf("d%0d in_ready", d), 64'(ir[d]), 64'(exp_ready(d)));
      for (int k = 0; k < nch[d]; k++) begin
        check($sformatf("d%0d out_valid[%0d]", d, k), 64'(ov[d][k]), 64'(q[d][k].size() != 0));
        check($sformatf("d%0d out_data[%0d]", d, k), 64'(od[d][k]), 64'(last[d][k]));
        if (q[d][k].size() != 0) any = 1'b1;
      end
      check($sformatf("d%0d busy", d), 64'(bsy[d]), 64'(any));
      check($sformatf("d%0d drop_count", d), 64'(drp[d]), 64'(drops[d]));
    end
  endtask

  task automatic advance();
    logic rdy;
    int   s;
    for (int d = 0; d < 2; d++) begin
      rdy = exp_ready(d);
      s   = int'(sel[d]);
      for (int k = 0; k < nch[d]; k++)
        if (q[d][k].size() != 0 && ordy[d][k]) void'(q[d][k].pop_front());
      if (iv[d] && rdy) begin
        if (s < nch[d]) begin
          q[d][s].push_back(din[d]);
          last[d][s] = din[d];
        end else if (drops[d] < 255) begin
          drops[d]++;
        end
      end
    end
  endtask

  // Check at the falling edge, then let the model follow the rising edge
  task automatic tick();
    @(negedge clk);
    verify();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; sel[d] = '0; din[d] = '0; ordy[d] = 4'hF;
    end
  endtask

  initial begin
    idle_inputs();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready4", 64'(ir[0]), 64'd0);
    check("reset in_ready3", 64'(ir[1]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tick();

    // Back-to-back words to every channel with all consumers ready
    for (int k = 0; k < 4; k++) begin
      iv[0] = 1'b1; sel[0] = 2'(k); din[0] = 32'hA0 + 32'(k);
      tick();
      check("t1 out_valid", 64'(ov[0][k]), 64'd1);
      check("t1 out_data", 64'(od[0][k]), 64'hA0 + 64'(k));
    end
    iv[0] = 1'b0;
    tick();

    // Stall channel 2, block a second word to it, pass a word to channel 1
    ordy[0] = 4'b1011;
    iv[0] = 1'b1; sel[0] = 2'd2; din[0] = 32'h11;
    tick();
    din[0] = 32'h22;
    tick();
    check("t2 in_ready blocked", 64'(ir[0]), 64'd0);
    check("t2 held data", 64'(od[0][2]), 64'h11);
    sel[0] = 2'd1; din[0] = 32'h33;
    tick();
    check("t3 ch1 data", 64'(od[0][1]), 64'h33);
    check("t3 ch2 still held", 64'(od[0][2]), 64'h11);
    sel[0] = 2'd2; din[0] = 32'h22; ordy[0] = 4'hF;
    tick();
    check("t2 refill data", 64'(od[0][2]), 64'h22);
    check("t2 refill valid", 64'(ov[0][2]), 64'd1);
    iv[0] = 1'b0;
    tick();

    // Out-of-range selector on the 3-channel instance saturates the drop count
    iv[1] = 1'b1; sel[1] = 2'd3; din[1] = 32'hDEAD;
    for (int i = 0; i < 300; i++) tick();
    iv[1] = 1'b0;
    tick();
    check("t4 drop saturated", 64'(drp[1]), 64'hFF);
    check("t4 no out_valid", 64'(ov[1]), 64'd0);

    // Fill every slot, then reset asynchronously in the middle of a cycle
    ordy[0] = 4'h0;
    for (int k = 0; k < 4; k++) begin
      iv[0] = 1'b1; sel[0] = 2'(k); din[0] = 32'hC0DE0000 + 32'(k);
      tick();
    end
    iv[0] = 1'b0;
    tick();
    check("t5 all full", 64'(ov[0]), 64'hF);
    #2 reset = 1'b1;
    #1;
    check("t5 in_ready4", 64'(ir[0]), 64'd0);
    check("t5 out_valid4", 64'(ov[0]), 64'd0);
    for (int k = 0; k < 4; k++) check("t5 out_data4", 64'(od[0][k]), 64'd0);
    check("t5 drop3", 64'(drp[1]), 64'd0);
    check("t5 busy4", 64'(bsy[0]), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    check("t5 in_ready3", 64'(ir[1]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic on both instances against the model
    for (int i = 0; i < 10000; i++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = ($urandom_range(0, 3) != 0);
        sel[d]  = 2'($urandom_range(0, 3));
        din[d]  = $urandom;
        ordy[d] = 4'($urandom);
      end
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
